// File: rtl/mult_div_unit_pkg.sv
// Shared MD op encodings for the EX-stage HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned WIDTH_MDOP = 3;

  localparam logic [WIDTH_MDOP-1:0] MD_MULT  = 3'd0;
  localparam logic [WIDTH_MDOP-1:0] MD_MULTU = 3'd1;
  localparam logic [WIDTH_MDOP-1:0] MD_DIV   = 3'd2;
  localparam logic [WIDTH_MDOP-1:0] MD_DIVU  = 3'd3;
  localparam logic [WIDTH_MDOP-1:0] MD_MTHI  = 3'd4;
  localparam logic [WIDTH_MDOP-1:0] MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product or quotient/remainder for the MD unit.
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [WIDTH_MDOP-1:0] op,
  input  logic [31:0]           rs,
  input  logic [31:0]           rt,
  output logic [31:0]           res_hi,
  output logic [31:0]           res_lo,
  output logic                  div_zero
);

  logic        sgn, is_div;
  logic        rs_neg, rt_neg;
  logic [63:0] prod;
  logic [31:0] rs_mag, rt_mag, divisor, q_mag, r_mag, quot, rem;

  assign sgn    = (op == MD_MULT) || (op == MD_DIV);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);

  // Low 64 bits of the extended product are correct for both signednesses.
  assign prod = {{32{sgn & rs[31]}}, rs} * {{32{sgn & rt[31]}}, rt};

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign rs_neg   = sgn & rs[31];
  assign rt_neg   = sgn & rt[31];
  assign rs_mag   = rs_neg ? (~rs + 32'd1) : rs;
  assign rt_mag   = rt_neg ? (~rt + 32'd1) : rt;
  assign div_zero = (rt == 32'd0);
  assign divisor  = div_zero ? 32'd1 : rt_mag;
  assign q_mag    = rs_mag / divisor;
  assign r_mag    = rs_mag % divisor;
  assign quot     = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = rs_neg ? (~r_mag + 32'd1) : r_mag;

  assign res_hi = is_div ? rem  : prod[63:32];
  assign res_lo = is_div ? quot : prod[31:0];

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency MULT/DIV, single-cycle MTHI/MTLO, HI/LO storage.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  md_start,
  input  logic [WIDTH_MDOP-1:0] md_op,
  input  logic [31:0]           rs_val,
  input  logic [31:0]           rt_val,
  input  logic                  md_dis,
  output logic                  md_busy,
  output logic [31:0]           hi,
  output logic [31:0]           lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  if (MULT_CYCLES < 2 || DIV_CYCLES < 2) begin : g_bad_param
    $error("mult_div_unit: MULT_CYCLES and DIV_CYCLES must both be >= 2");
  end

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_skip_q, pend_skip_d;
  logic              accept, is_mult, is_div;
  logic [31:0]       res_hi, res_lo;
  logic              div_zero;

  md_arith u_md_arith (
    .op       (md_op),
    .rs       (rs_val),
    .rt       (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  assign is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign accept  = md_start && !md_dis && (state_q == StIdle) && !reset;
  assign md_busy = (state_q == StBusy) || (accept && (is_mult || is_div));
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_skip_d = pend_skip_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mult || is_div) begin
            pend_hi_d   = res_hi;
            pend_lo_d   = res_lo;
            pend_skip_d = is_div && div_zero;
            cnt_d       = is_mult ? CntW'(MULT_CYCLES - 1) : CntW'(DIV_CYCLES - 1);
            state_d     = StBusy;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(1)) begin
          if (!pend_skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_skip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_skip_q <= pend_skip_d;
    end
  end

`ifndef SYNTHESIS
  // The controller must stall MD instructions while an op is in flight.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    !(md_start && (state_q == StBusy)))
    else $error("mult_div_unit: md_start while busy");
`endif

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- EX-stage HI/LO multiply/divide unit.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, and MTHI/MTLO in a single cycle.
- Holds the architectural HI/LO registers.
- Produces the md_busy flag the pipeline controller uses to stall MD-class instructions in ID.
- Consumes the controller's disable flag so a flushed EX instruction never alters HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU including the start cycle.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU including the start cycle.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- md_start  in  1  EX instruction is an MD write-class op this cycle.
- md_op  in  3  op code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (shared constants).
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MT source).
- rt_val  in  32  forwarded rt operand (divisor / multiplier).
- md_dis  in  1  flush from controller; the EX instruction is being killed.
- md_busy  out  1  stall request to controller.
- hi  out  32  committed HI, read by MFHI.
- lo  out  32  committed LO, read by MFLO.

Behaviour:
- Accept condition: `accept = md_start && !md_dis && state==IDLE`. md_dis masks md_start in the same cycle only; an operation already in flight is unaffected.
- State machine, IDLE/BUSY:
  - IDLE, accept of a mult/div op: latch the 64-bit result into pending_hi/pending_lo. Load cnt with MULT_CYCLES-1 or DIV_CYCLES-1. Go to BUSY.
  - BUSY: cnt decrements each cycle. At cnt==1, the next edge commits pending into hi/lo, clears cnt and returns to IDLE.
- Result encoding:
  - MULT/MULTU: {hi,lo} = rs*rt as a 64-bit signed/unsigned product.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: the unit still goes busy for DIV_CYCLES, but hi/lo are left unchanged at commit.
- Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0.
- MTHI/MTLO: on accept, hi or lo is written at the next edge. No busy cycle; state stays IDLE.
- md_busy timing:
  - `md_busy = (state==BUSY) || (accept && op is mult/div)`.
  - md_busy is high in the start cycle, so an MD instruction in ID stalls immediately.
  - Total high cycles equal MULT_CYCLES / DIV_CYCLES.
  - hi/lo show the new value in the first cycle md_busy is low.
- md_start while BUSY is a protocol violation (the controller stalls it). Required response:
  - ignore the request;
  - keep the in-flight op;
  - fire a simulation-only assertion.
- hi/lo outputs are registered committed values. There is no forwarding of pending results.
- Reset: any time, including mid-op, asynchronously drives state=IDLE, cnt=0, hi=lo=0, pending=0, md_busy=0. The in-flight result is discarded.
- Width rules: cnt width is clog2(max(MULT_CYCLES,DIV_CYCLES))+1. Both parameters must be ≥2; a parameter of 1 is illegal and is asserted at elaboration.

Decomposition:
- Shared include alongside the instruction/exception defines holds:
  - the 3-bit MD op codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - WIDTH_MDOP.
- One sub-module, md_arith: purely combinational 64-bit product/quotient/remainder from op, rs, rt. It also flags div-by-zero.
- Controller FSM, counter and HI/LO storage stay in mult_div_unit.

Test Plan:
- MULT with rs=0xFFFFFFFE (-2), rt=3:
  - md_busy is high exactly 5 cycles from the start cycle;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- DIV with rs=-7, rt=2 → md_busy high 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU with rt=0 and prior hi=0x11, lo=0x22 → busy 10 cycles, then hi/lo still 0x11/0x22.
- MTHI rs=0xABCD0000 with md_dis=1 → hi unchanged, md_busy=0. Repeat with md_dis=0 → hi=0xABCD0000 next cycle, md_busy never high.
- Reset at cycle 3 of DIV:
  - busy drops immediately and hi=lo=0;
  - a new MULT 2*3 afterwards gives lo=6 after 5 cycles.
